// File: rtl/pf_pkg.sv
// Shared definitions for the frame transmitter: register map, ctrl/status bit
// positions and the transmit state encoding.
package pf_pkg;

  localparam logic [7:0] ADDR_GAP     = 8'd0;
  localparam logic [7:0] ADDR_LEN_LO  = 8'd1;
  localparam logic [7:0] ADDR_LEN_HI  = 8'd2;
  localparam logic [7:0] ADDR_CTRL    = 8'd3;
  localparam logic [7:0] ADDR_STATUS  = 8'd4;
  localparam logic [7:0] ADDR_CSUM0   = 8'd5;
  localparam logic [7:0] ADDR_CSUM1   = 8'd6;
  localparam logic [7:0] ADDR_CSUM2   = 8'd7;
  localparam logic [7:0] ADDR_CSUM3   = 8'd8;
  localparam logic [7:0] ADDR_PUSH    = 8'd9;
  localparam logic [7:0] ADDR_FILL_LO = 8'd10;
  localparam logic [7:0] ADDR_FILL_HI = 8'd11;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR_ERR = 1;
  localparam int CTRL_FLUSH   = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_LEN_ERR  = 2;
  localparam int ST_OVERFLOW = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP
  } tx_state_e;

endpackage

// File: rtl/frame_transmitter_if.sv
// Avalon-MM register port plus AXI-Stream egress port of the frame transmitter.
// slave is the transmitter's view, master is the host/sink side.
interface frame_transmitter_if;

  logic [7:0]  writedata;
  logic        write;
  logic        chipselect;
  logic [7:0]  address;
  logic        read;
  logic [7:0]  readdata;
  logic [15:0] egress_port_tdata;
  logic        egress_port_tvalid;
  logic        egress_port_tready;
  logic        egress_port_tlast;

  modport slave (
    input  writedata, write, chipselect, address, read, egress_port_tready,
    output readdata, egress_port_tdata, egress_port_tvalid, egress_port_tlast
  );

  modport master (
    output writedata, write, chipselect, address, read, egress_port_tready,
    input  readdata, egress_port_tdata, egress_port_tvalid, egress_port_tlast
  );

endinterface

// File: rtl/tx_byte_fifo.sv
// Payload byte FIFO: one byte in per push, one or two bytes out per pop.
// Pushes into a full FIFO are dropped and flagged on overflow for one cycle.
module tx_byte_fifo #(
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic [1:0]               pop_cnt,
  output logic [7:0]               pop_data0,
  output logic [7:0]               pop_data1,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push_ok;

  // fill never exceeds DEPTH, so its top bit alone marks full
  assign full      = fill[AW];
  assign push_ok   = push && !full;
  assign overflow  = push && full;
  assign pop_data0 = mem[rd_ptr];
  assign pop_data1 = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_cnt);
      fill   <= fill + FW'(push_ok) - FW'(pop_cnt);
    end
  end

endmodule

// File: rtl/frame_transmitter.sv
// Frame transmitter: software-loaded payload FIFO streamed as 16-bit AXI-Stream
// beats with tlast and a programmable inter-frame gap.
module frame_transmitter
  import pf_pkg::*;
#(
  parameter int FIFO_DEPTH = 2048
) (
  input logic               clk,
  input logic               reset,
  frame_transmitter_if.slave bus
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e    state;
  logic [7:0]   gap_reg, gap_lat, gap_cnt;
  logic [15:0]  len_reg, rem;
  logic [31:0]  checksum;
  logic         done, len_err, overflow;
  logic [15:0]  tdata;
  logic         tvalid, tlast;
  logic [7:0]   readdata, rd_mux, status;

  logic [FW-1:0] fifo_fill;
  logic [15:0]   fill16, avail;
  logic [7:0]    pop_d0, pop_d1;
  logic [1:0]    pop_cnt;
  logic          fifo_ovf;
  logic          wr_en, rd_en, ctrl_wr, push, idle, flush;
  logic          start_req, start_bad, hs, load;

  assign wr_en     = bus.chipselect && bus.write;
  assign rd_en     = bus.chipselect && bus.read;
  assign ctrl_wr   = wr_en && (bus.address == ADDR_CTRL);
  assign push      = wr_en && (bus.address == ADDR_PUSH);
  assign idle      = (state == TX_IDLE);
  assign flush     = ctrl_wr && bus.writedata[CTRL_FLUSH] && idle;
  assign fill16    = 16'(fifo_fill);
  // a FLUSH in the same write as START leaves nothing to send
  assign avail     = flush ? 16'd0 : fill16;
  assign start_req = ctrl_wr && bus.writedata[CTRL_START] && idle;
  assign start_bad = (len_reg == 16'd0) || (len_reg > avail);
  assign hs        = tvalid && bus.egress_port_tready;
  assign load      = (state == TX_SEND) && (rem != 16'd0) && (!tvalid || hs);
  assign pop_cnt   = load ? ((rem == 16'd1) ? 2'd1 : 2'd2) : 2'd0;

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (bus.writedata),
    .pop_cnt   (pop_cnt),
    .pop_data0 (pop_d0),
    .pop_data1 (pop_d1),
    .fill      (fifo_fill),
    .overflow  (fifo_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      gap_reg  <= '0;
      gap_lat  <= '0;
      gap_cnt  <= '0;
      len_reg  <= '0;
      rem      <= '0;
      checksum <= '0;
      done     <= 1'b0;
      len_err  <= 1'b0;
      overflow <= 1'b0;
      tdata    <= '0;
      tvalid   <= 1'b0;
      tlast    <= 1'b0;
    end else begin
      if (wr_en) begin
        case (bus.address)
          ADDR_GAP:    gap_reg       <= bus.writedata;
          ADDR_LEN_LO: len_reg[7:0]  <= bus.writedata;
          ADDR_LEN_HI: len_reg[15:8] <= bus.writedata;
          default: ;
        endcase
      end
      if (fifo_ovf) overflow <= 1'b1;
      if (ctrl_wr && bus.writedata[CTRL_CLR_ERR]) begin
        len_err  <= 1'b0;
        overflow <= 1'b0;
      end
      if (hs) checksum <= checksum + 32'(tdata[7:0]) + 32'(tdata[15:8]);

      case (state)
        TX_IDLE: begin
          if (start_req) begin
            if (start_bad) begin
              len_err <= 1'b1;
            end else begin
              rem      <= len_reg;
              gap_lat  <= gap_reg;
              checksum <= '0;
              done     <= 1'b0;
              state    <= TX_SEND;
            end
          end
        end
        TX_SEND: begin
          if (load) begin
            tvalid <= 1'b1;
            tlast  <= (rem <= 16'd2);
            tdata  <= (rem == 16'd1) ? {8'h00, pop_d0} : {pop_d1, pop_d0};
            rem    <= rem - ((rem == 16'd1) ? 16'd1 : 16'd2);
          end else if (hs) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
          end
          if (hs && tlast) begin
            if (gap_lat == 8'd0) begin
              state <= TX_IDLE;
              done  <= 1'b1;
            end else begin
              gap_cnt <= gap_lat;
              state   <= TX_GAP;
            end
          end
        end
        TX_GAP: begin
          if (gap_cnt == 8'd1) begin
            state <= TX_IDLE;
            done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = !idle;
    status[ST_DONE]      = done;
    status[ST_LEN_ERR]   = len_err;
    status[ST_OVERFLOW]  = overflow;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_GAP:     rd_mux = gap_reg;
      ADDR_LEN_LO:  rd_mux = len_reg[7:0];
      ADDR_LEN_HI:  rd_mux = len_reg[15:8];
      ADDR_STATUS:  rd_mux = status;
      ADDR_CSUM0:   rd_mux = checksum[7:0];
      ADDR_CSUM1:   rd_mux = checksum[15:8];
      ADDR_CSUM2:   rd_mux = checksum[23:16];
      ADDR_CSUM3:   rd_mux = checksum[31:24];
      ADDR_FILL_LO: rd_mux = fill16[7:0];
      ADDR_FILL_HI: rd_mux = fill16[15:8];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !rd_en) readdata <= '0;
    else                 readdata <= rd_mux;
  end

  assign bus.readdata           = readdata;
  assign bus.egress_port_tdata  = tdata;
  assign bus.egress_port_tvalid = tvalid;
  assign bus.egress_port_tlast  = tlast;

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter: register vector table plus hand-written
// frame sequences checked against a byte-level model of the egress stream.
module tb_frame_transmitter;

  localparam int DEPTH = 64;
  localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_IDLE = 2'd2;

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } reg_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_transmitter_if bus();
  frame_transmitter #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  wire        tv = bus.egress_port_tvalid;
  wire        tr = bus.egress_port_tready;
  wire        tl = bus.egress_port_tlast;
  wire [15:0] td = bus.egress_port_tdata;

  int          errors = 0;
  int          checks = 0;
  bit          rnd_ready = 1'b0;
  logic [16:0] got[$];
  logic [16:0] exp_q[$];
  logic [7:0]  tx_bytes[$];
  logic [31:0] model_csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic av_write(input logic [7:0] a, input logic [7:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic av_read(input logic [7:0] a, output logic [7:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic read_csum(output logic [31:0] c);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      av_read(8'(5 + i), b);
      c[i*8 +: 8] = b;
    end
  endtask

  task automatic read_fill(output logic [15:0] f);
    logic [7:0] b;
    av_read(8'd10, b); f[7:0] = b;
    av_read(8'd11, b); f[15:8] = b;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit keep);
    av_write(8'd9, b);
    if (keep) tx_bytes.push_back(b);
  endtask

  // START then confirm the first beat shows up within two cycles
  task automatic start_frame(input logic [15:0] len, input logic [7:0] gap, input string tag);
    bit seen = 1'b0;
    got.delete();
    av_write(8'd0, gap);
    av_write(8'd1, len[7:0]);
    av_write(8'd2, len[15:8]);
    av_write(8'd3, 8'h01);
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk);
      if (tv) seen = 1'b1;
    end
    check({tag, " first tvalid latency"}, 32'(seen), 32'd1);
  endtask

  // wait for the tlast handshake, then count busy samples with status held in read
  task automatic finish_frame(input int gap, input string tag, output logic [7:0] st);
    bit seen = 1'b0;
    bit valid_in_gap = 1'b0;
    int n = 0;
    st = 8'hFF;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (tv && tr && tl) seen = 1'b1;
    end
    check({tag, " tlast handshake"}, 32'(seen), 32'd1);
    if (!seen) return;
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 8'd4;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      st = bus.readdata;
      if (tv) valid_in_gap = 1'b1;
      if (!st[0]) break;
      n++;
    end
    bus.chipselect = 1'b0; bus.read = 1'b0;
    check({tag, " busy samples after tlast"}, 32'(n), 32'(gap + 1));
    check({tag, " tvalid low in gap"}, 32'(valid_in_gap), 32'd0);
  endtask

  task automatic build_expected(input int len);
    logic [7:0] lo, hi;
    exp_q.delete();
    model_csum = '0;
    for (int i = 0; i < len; i += 2) begin
      lo = tx_bytes[i];
      hi = (i + 1 < len) ? tx_bytes[i+1] : 8'h00;
      exp_q.push_back({(i + 2 >= len), hi, lo});
      model_csum = model_csum + 32'(lo) + 32'(hi);
    end
  endtask

  task automatic compare_beats(input string tag);
    check({tag, " beat count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s beat%0d {tlast,tdata}", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic monitor();
    bit          stall = 1'b0;
    logic [15:0] pd = '0;
    logic        pl = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) check("stalled beat held", 32'({tv, pl, pd}) ^ 32'({tv, tl, td}) ^ 32'({tv, pl, pd}),
                         32'({1'b1, pl, pd}));
        if (tv && tr) got.push_back({tl, td});
        stall = tv && !tr;
        pd = td;
        pl = tl;
      end
    end
  endtask

  initial begin
    reg_vec_t    vecs[$];
    logic [7:0]  rd, st;
    logic [15:0] f;
    logic [31:0] c;
    logic [7:0]  zaddr[10];
    int          hs_cnt;

    bus.writedata = '0; bus.write = 1'b0; bus.chipselect = 1'b0;
    bus.address = '0; bus.read = 1'b0; bus.egress_port_tready = 1'b1;

    fork
      monitor();
      forever begin
        @(posedge clk); #1;
        if (rnd_ready) bus.egress_port_tready = 1'($urandom_range(0, 1));
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset tvalid", 32'(tv), 32'd0);
    check("reset tlast", 32'(tl), 32'd0);
    check("reset tdata", 32'(td), 32'd0);
    check("reset readdata", 32'(bus.readdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ---- register vector table ----
    vecs.push_back('{OP_RD,   8'd0,   8'h00, 8'h00});
    vecs.push_back('{OP_RD,   8'd1,   8'h00, 8'h00});
    vecs.push_back('{OP_RD,   8'd2,   8'h00, 8'h00});
    vecs.push_back('{OP_RD,   8'd4,   8'h00, 8'h00});
    vecs.push_back('{OP_RD,   8'd5,   8'h00, 8'h00});
    vecs.push_back('{OP_RD,   8'd10,  8'h00, 8'h00});
    vecs.push_back('{OP_WR,   8'd0,   8'h5A, 8'h00});
    vecs.push_back('{OP_RD,   8'd0,   8'h00, 8'h5A});
    vecs.push_back('{OP_IDLE, 8'd0,   8'h00, 8'h00});
    vecs.push_back('{OP_WR,   8'd1,   8'h34, 8'h00});
    vecs.push_back('{OP_RD,   8'd1,   8'h00, 8'h34});
    vecs.push_back('{OP_WR,   8'd2,   8'h12, 8'h00});
    vecs.push_back('{OP_RD,   8'd2,   8'h00, 8'h12});
    vecs.push_back('{OP_RD,   8'd3,   8'h00, 8'h00});
    vecs.push_back('{OP_RD,   8'd9,   8'h00, 8'h00});
    vecs.push_back('{OP_RD,   8'd12,  8'h00, 8'h00});
    vecs.push_back('{OP_WR,   8'd200, 8'hFF, 8'h00});
    vecs.push_back('{OP_RD,   8'd200, 8'h00, 8'h00});
    vecs.push_back('{OP_RD,   8'd0,   8'h00, 8'h5A});
    vecs.push_back('{OP_RD,   8'd255, 8'h00, 8'h00});
    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_WR: av_write(vecs[i].addr, vecs[i].data);
        OP_RD: begin
          av_read(vecs[i].addr, rd);
          check($sformatf("vec%0d read addr %0d", i, vecs[i].addr), 32'(rd), 32'(vecs[i].exp));
        end
        default: begin
          @(negedge clk);
          check($sformatf("vec%0d readdata idle", i), 32'(bus.readdata), 32'(vecs[i].exp));
        end
      endcase
    end

    // ---- length error: len=8, fill=6 ----
    for (int i = 0; i < 6; i++) push_byte(8'(8'hA0 + i), 1'b0);
    av_write(8'd1, 8'd8);
    av_write(8'd2, 8'd0);
    av_write(8'd3, 8'h01);
    begin
      bit any_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (tv) any_valid = 1'b1;
      end
      check("len_err no tvalid", 32'(any_valid), 32'd0);
    end
    av_read(8'd4, st);
    check("len_err status", 32'(st), 32'h04);
    av_write(8'd3, 8'h03);
    av_read(8'd4, st);
    check("clr+start same write status", 32'(st), 32'h04);
    av_write(8'd3, 8'h02);
    av_read(8'd4, st);
    check("clr_err status", 32'(st), 32'h00);
    read_fill(f);
    check("fill before flush", 32'(f), 32'd6);
    av_write(8'd3, 8'h04);
    read_fill(f);
    check("fill after flush", 32'(f), 32'd0);

    // ---- frame 1: 4 bytes, gap 3 ----
    tx_bytes.delete();
    push_byte(8'h11, 1'b1); push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1); push_byte(8'h44, 1'b1);
    start_frame(16'd4, 8'd3, "f1");
    finish_frame(3, "f1", st);
    check("f1 status", 32'(st), 32'h02);
    exp_q.delete();
    exp_q.push_back(17'h02211);
    exp_q.push_back(17'h14433);
    compare_beats("f1");
    read_csum(c);
    check("f1 checksum", c, 32'h000000AA);

    // ---- frame 2: 5 bytes, odd tail, gap 0 ----
    tx_bytes.delete();
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b1);
    start_frame(16'd5, 8'd0, "f2");
    finish_frame(0, "f2", st);
    check("f2 status", 32'(st), 32'h02);
    exp_q.delete();
    exp_q.push_back(17'h00201);
    exp_q.push_back(17'h00403);
    exp_q.push_back(17'h10005);
    compare_beats("f2");
    read_fill(f);
    check("f2 fill at end", 32'(f), 32'd0);
    read_csum(c);
    check("f2 checksum", c, 32'h0000000F);

    // ---- frame 3: 64 bytes, random backpressure ----
    tx_bytes.delete();
    for (int i = 0; i < 64; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
    rnd_ready = 1'b1;
    start_frame(16'd64, 8'd2, "f3");
    finish_frame(2, "f3", st);
    rnd_ready = 1'b0;
    bus.egress_port_tready = 1'b1;
    build_expected(64);
    compare_beats("f3");
    read_csum(c);
    check("f3 checksum", c, model_csum);

    // ---- frame 4: overflow at FIFO_DEPTH ----
    tx_bytes.delete();
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
    push_byte(8'hEE, 1'b0);
    av_read(8'd4, st);
    check("overflow bit", 32'(st[3]), 32'd1);
    read_fill(f);
    check("fill at full", 32'(f), 32'(DEPTH));
    start_frame(16'(DEPTH), 8'd1, "f4");
    finish_frame(1, "f4", st);
    check("f4 status", 32'(st), 32'h0A);
    build_expected(DEPTH);
    compare_beats("f4");
    read_csum(c);
    check("f4 checksum", c, model_csum);
    read_fill(f);
    check("f4 fill at end", 32'(f), 32'd0);

    // ---- reset in the middle of a 10-byte frame ----
    av_write(8'd3, 8'h02);
    for (int i = 0; i < 10; i++) push_byte(8'(8'h60 + i), 1'b0);
    start_frame(16'd10, 8'd4, "f5");
    hs_cnt = (tv && tr) ? 1 : 0;
    for (int i = 0; i < 50 && hs_cnt < 2; i++) begin
      @(negedge clk);
      if (tv && tr) hs_cnt++;
    end
    check("f5 two beats before reset", 32'(hs_cnt), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid-frame reset tvalid", 32'(tv), 32'd0);
    check("mid-frame reset tlast", 32'(tl), 32'd0);
    reset = 1'b0;
    zaddr = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11};
    for (int i = 0; i < 10; i++) begin
      av_read(zaddr[i], rd);
      check($sformatf("post-reset read addr %0d", zaddr[i]), 32'(rd), 32'd0);
    end
    repeat (5) @(negedge clk);
    check("post-reset idle tvalid", 32'(tv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
